enemy_rom_arbiter: RTL

//  Shares one synchronous enemy sprite ROM (12-bit RGB, 1-cycle read latency) among N_REQ enemy renderers.

---
 rtl/enemy_sprite_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/enemy_rom_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/enemy_sprite_pkg.sv
// rtl/enemy_sprite_pkg.sv - shared enemy sprite geometry and ROM address helper
package enemy_sprite_pkg;
  localparam int FRAME_W       = 64;
  localparam int FRAME_H       = 56;
  localparam int N_FRAMES      = 3;
  localparam int FRAME_SIZE    = FRAME_W * FRAME_H;
  localparam int FRAME_IDX_W   = 2;
  localparam int Y_W           = 6;
  localparam int X_W           = 6;
  localparam int SPRITE_ADDR_W = 14;
  localparam logic [11:0] TRANSPARENT = 12'h0F0;

  // frame*3584 = (frame<<11)+(frame<<10)+(frame<<9); the largest sum (14847) fits in 14 bits
  function automatic logic [SPRITE_ADDR_W-1:0] sprite_addr(
    input logic [FRAME_IDX_W-1:0] frame,
    input logic [Y_W-1:0]         y,
    input logic [X_W-1:0]         x
  );
    logic [SPRITE_ADDR_W-1:0] f;
    f = SPRITE_ADDR_W'(frame);
    return (f << 11) + (f << 10) + (f << 9) + SPRITE_ADDR_W'({y, x});
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with registered last-winner pointer
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % N);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
    ptr_d = found ? gnt_id : ptr_q;
  end

  // A grant only goes to an asserted request, so every grant is an acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= ID_W'(N - 1);
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/enemy_rom_arbiter.sv
// rtl/enemy_rom_arbiter.sv - shares one enemy sprite ROM among N_REQ renderers
module enemy_rom_arbiter
  import enemy_sprite_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req,
  input  logic [2*N_REQ-1:0]      req_frame,
  input  logic [6*N_REQ-1:0]      req_y,
  input  logic [6*N_REQ-1:0]      req_x,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_WIDTH-1:0]   rsp_data
);
  logic [ID_W-1:0]        gnt_id;
  logic                   accept;
  logic [FRAME_IDX_W-1:0] sel_frame;
  logic [Y_W-1:0]         sel_y;
  logic [X_W-1:0]         sel_x;
  logic                   sel_oob;

  logic [ADDR_WIDTH-1:0]  rom_addr_q;
  logic                   v1_q, oob1_q, oob2_q, rsp_valid_q;
  logic [ID_W-1:0]        id1_q, rsp_id_q;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign accept = |gnt;

  always_comb begin
    sel_frame = '0;
    sel_y     = '0;
    sel_x     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_frame = req_frame[FRAME_IDX_W*i +: FRAME_IDX_W];
        sel_y     = req_y[Y_W*i +: Y_W];
        sel_x     = req_x[X_W*i +: X_W];
      end
    end
    sel_oob = (sel_frame >= FRAME_IDX_W'(N_FRAMES)) || (sel_y >= Y_W'(FRAME_H));
  end

  // Out-of-range requests still occupy a pipeline slot but leave the ROM address alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr_q  <= '0;
      v1_q        <= 1'b0;
      id1_q       <= '0;
      oob1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      oob2_q      <= 1'b0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        id1_q  <= gnt_id;
        oob1_q <= sel_oob;
        if (!sel_oob) rom_addr_q <= ADDR_WIDTH'(sprite_addr(sel_frame, sel_y, sel_x));
      end
      rsp_valid_q <= v1_q;
      rsp_id_q    <= id1_q;
      oob2_q      <= oob1_q;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = oob2_q ? DATA_WIDTH'(TRANSPARENT) : rom_data;
endmodule
